// File: rtl/playfield_framer.sv
// playfield_framer: double-buffered cell playfield with vsync-timed bank swap, back-bank clear and post-swap copy.
module playfield_framer #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int PIX_W  = 3,
  parameter int FCNT_W = 11
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic                      wr_en,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [PIX_W-1:0]          wr_data,
  input  logic                      commit,
  input  logic                      clr_req,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  output logic [PIX_W-1:0]          rd_data,
  output logic                      busy,
  output logic                      swap_pulse,
  output logic [FCNT_W-1:0]         frame_count
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  typedef enum logic [1:0] {INIT, IDLE, CLEAR, COPY} state_t;
  state_t r_state, w_next;
  logic [PIX_W-1:0]  r_bank0 [0:N-1];
  logic [PIX_W-1:0]  r_bank1 [0:N-1];
  logic              r_front, r_vsync, r_cp, r_swap;
  logic [CW-1:0]     r_scol;
  logic [RW-1:0]     r_srow;
  logic [FCNT_W-1:0] r_fcnt;
  logic [PIX_W-1:0]  r_rd;
  logic              w_rise, w_swap, w_last, w_busy, w_init, w_wr_ok, w_rd_ok, w_bwe;
  logic [AW-1:0]     w_sidx, w_widx, w_ridx, w_bwa;
  logic [PIX_W-1:0]  w_fsrc, w_bwd;
  assign w_rise  = vsync & ~r_vsync;
  assign w_swap  = (r_state == IDLE) & w_rise & r_cp;
  assign w_last  = (r_scol == CW'(COLS - 1)) && (r_srow == RW'(ROWS - 1));
  assign w_sidx  = AW'(int'(r_srow) * COLS + int'(r_scol));
  assign w_widx  = AW'(int'(wr_row) * COLS + int'(wr_col));
  assign w_ridx  = AW'(int'(rd_row) * COLS + int'(rd_col));
  assign w_rd_ok = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);
  assign w_fsrc  = r_front ? r_bank1[w_sidx] : r_bank0[w_sidx];
  always_ff @(posedge clock) r_state <= reset ? INIT : w_next;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_swap ? COPY : clr_req ? CLEAR : IDLE)
                               : (w_last ? IDLE : r_state);
  end
  always_comb begin
    w_busy  = r_state != IDLE;
    w_init  = r_state == INIT;
    w_wr_ok = !w_busy && wr_en && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
    w_bwe   = !reset && (w_busy || w_wr_ok);
    w_bwa   = w_busy ? w_sidx : w_widx;
    w_bwd   = (r_state == COPY) ? w_fsrc : (r_state == IDLE) ? wr_data : '0;
  end
  // The back bank is the one not selected by r_front; INIT zeroes both at once.
  always_ff @(posedge clock) begin
    if (w_bwe && (r_front || w_init)) r_bank0[w_bwa] <= w_bwd;
    if (w_bwe && (!r_front || w_init)) r_bank1[w_bwa] <= w_bwd;
  end
  always_ff @(posedge clock) begin
    if (reset || !w_busy || w_last) begin
      r_scol <= '0;
      r_srow <= '0;
    end else if (r_scol == CW'(COLS - 1)) begin
      r_scol <= '0;
      r_srow <= r_srow + 1'b1;
    end else begin
      r_scol <= r_scol + 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    r_vsync <= vsync;
    if (reset) begin
      r_front <= 1'b0;
      r_fcnt  <= '0;
      r_rd    <= '0;
      r_swap  <= 1'b0;
      r_cp    <= 1'b0;
    end else begin
      r_front <= r_front ^ w_swap;
      r_fcnt  <= r_fcnt + FCNT_W'(w_rise);
      r_swap  <= w_swap;
      r_cp    <= commit | (r_cp & ~w_swap);
      r_rd    <= !w_rd_ok ? '0 : r_front ? r_bank1[w_ridx] : r_bank0[w_ridx];
    end
  end
  assign rd_data     = r_rd;
  assign busy        = w_busy;
  assign swap_pulse  = r_swap;
  assign frame_count = r_fcnt;
endmodule

// File: tb/tb_playfield_framer.sv
// tb_playfield_framer: directed scoreboard bench for playfield_framer with a bank-level reference model.
module tb_playfield_framer;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int N    = COLS * ROWS;
  logic        clock = 1'b0, reset = 1'b1, vsync = 1'b0, wr_en = 1'b0, commit = 1'b0, clr_req = 1'b0;
  logic [3:0]  wr_col = '0, rd_col = '0;
  logic [4:0]  wr_row = '0, rd_row = '0;
  logic [2:0]  wr_data = '0;
  logic [2:0]  rd_data;
  logic        busy, swap_pulse;
  logic [10:0] frame_count;
  int checks = 0, errors = 0, nrise = 0, sw = 0;
  int m_front [N];
  int m_back  [N];
  int exp_q [$];
  always #5 clock = ~clock;
  playfield_framer #(.COLS(COLS), .ROWS(ROWS), .PIX_W(3), .FCNT_W(11)) dut (
    .clock(clock), .reset(reset), .vsync(vsync), .wr_en(wr_en),
    .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .commit(commit), .clr_req(clr_req), .rd_col(rd_col), .rd_row(rd_row),
    .rd_data(rd_data), .busy(busy), .swap_pulse(swap_pulse), .frame_count(frame_count)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic rd(int c, int r);
    rd_col = 4'(c);
    rd_row = 5'(r);
    exp_q.push_back((c < COLS && r < ROWS) ? m_front[r * COLS + c] : 0);
    tick();
    chk("rd_data", int'(rd_data), exp_q.pop_front());
  endtask
  task automatic wr(int c, int r, int d, bit takes);
    wr_en = 1'b1;
    wr_col = 4'(c);
    wr_row = 5'(r);
    wr_data = 3'(d);
    tick();
    wr_en = 1'b0;
    if (takes) m_back[r * COLS + c] = d;
  endtask
  task automatic wait_idle(string tag, int exp);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, n, exp);
  endtask
  task automatic swap_model();
    int t;
    for (int i = 0; i < N; i++) begin
      t = m_front[i];
      m_front[i] = m_back[i];
      m_back[i] = t;
    end
  endtask
  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask
  task automatic vs_rise(bit with_clr);
    vsync = 1'b1;
    clr_req = with_clr;
    tick();
    nrise++;
    chk("swap_pulse_on", int'(swap_pulse), 1);
    vsync = 1'b0;
    clr_req = 1'b0;
    swap_model();
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      m_front[i] = 0;
      m_back[i] = 0;
    end
    tick();
    tick();
    reset = 1'b0;
    chk("busy_after_reset", int'(busy), 1);
    chk("frame_count_reset", int'(frame_count), 0);
    chk("swap_pulse_reset", int'(swap_pulse), 0);
    chk("rd_data_reset", int'(rd_data), 0);
    repeat (100) tick();
    chk("busy_mid_init", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle("init_len", 200);
    chk("frame_count_idle", int'(frame_count), 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) rd(c, r);
    rd(12, 5);
    rd(3, 31);
    wr(3, 5, 5, 1);
    wr(12, 0, 7, 0);
    pulse_commit();
    chk("commit_no_busy", int'(busy), 0);
    vs_rise(0);
    chk("busy_copy", int'(busy), 1);
    rd(3, 5);
    chk("swap_pulse_once", int'(swap_pulse), 0);
    rd(2, 1);
    rd(12, 5);
    wr(3, 5, 2, 0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    pulse_commit();
    wait_idle("copy_len", 194);
    m_back = m_front;
    tick();
    chk("clr_ignored_busy", int'(busy), 0);
    vs_rise(0);
    rd(3, 5);
    wait_idle("copy_len2", 199);
    m_back = m_front;
    wr(0, 0, 6, 1);
    pulse_commit();
    vs_rise(1);
    rd(0, 0);
    wait_idle("copy_len3", 199);
    m_back = m_front;
    tick();
    chk("clr_dropped", int'(busy), 0);
    pulse_commit();
    vs_rise(0);
    rd(0, 0);
    rd(3, 5);
    wait_idle("copy_len4", 198);
    m_back = m_front;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("busy_clear", int'(busy), 1);
    wait_idle("clear_len", 200);
    for (int i = 0; i < N; i++) m_back[i] = 0;
    pulse_commit();
    vs_rise(0);
    rd(0, 0);
    rd(3, 5);
    wait_idle("copy_len5", 198);
    m_back = m_front;
    chk("frame_count_run", int'(frame_count), nrise);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle("init_len2", 200);
    for (int i = 0; i < 2047; i++) begin
      vsync = 1'b1;
      tick();
      sw += int'(swap_pulse);
      vsync = 1'b0;
      tick();
      sw += int'(swap_pulse);
    end
    chk("frame_count_2047", int'(frame_count), 2047);
    vsync = 1'b1;
    tick();
    sw += int'(swap_pulse);
    vsync = 1'b0;
    tick();
    sw += int'(swap_pulse);
    chk("frame_count_wrap", int'(frame_count), 0);
    chk("no_swap_without_commit", sw, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/playfield_framer.md
PLAYFIELD_FRAMER -- requirements
Module: playfield_framer

Interface
REQ-001 SHALL have parameter COLS, default 10, meaning playfield width in cells.
REQ-002 SHALL have parameter ROWS, default 20, meaning playfield height in cells.
REQ-003 SHALL have parameter PIX_W, default 3, meaning colour bits per cell.
REQ-004 SHALL have parameter FCNT_W, default 11, meaning frame counter width.
REQ-005 SHALL have port clock, input, 1, meaning single clock; all logic posedge clock.
REQ-006 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port vsync, input, 1, meaning VGA vertical sync, sampled synchronously.
REQ-008 SHALL have port wr_en, input, 1, meaning write one cell of the back bank.
REQ-009 SHALL have ports wr_col and wr_row, input, clog2(COLS) and clog2(ROWS), meaning write address.
REQ-010 SHALL have port wr_data, input, PIX_W, meaning write colour.
REQ-011 SHALL have port commit, input, 1, meaning request back/front swap at next vsync.
REQ-012 SHALL have port clr_req, input, 1, meaning request zeroing of the back bank.
REQ-013 SHALL have ports rd_col and rd_row, input, clog2(COLS) and clog2(ROWS), meaning display read address.
REQ-014 SHALL have port rd_data, output, PIX_W, meaning front-bank colour, registered.
REQ-015 SHALL have port busy, output, 1, meaning sweep in progress; writes are ignored.
REQ-016 SHALL have port swap_pulse, output, 1, meaning one-cycle strobe on bank swap.
REQ-017 SHALL have port frame_count, output, FCNT_W, meaning vsync rising-edge count.

Function
REQ-018 SHALL hold two banks of COLS*ROWS cells, PIX_W bits each; front_sel selects the display bank.
REQ-019 SHALL detect a vsync rise as vsync=1 while the previously registered vsync=0; this takes 1 cycle.
REQ-020 SHALL increment frame_count on every vsync rise, with modulo-2^FCNT_W wrap, regardless of state.
REQ-021 SHALL return rd_data = front[rd_row][rd_col] one cycle after the address is presented; an out-of-range address returns 0.
REQ-022 SHALL write wr_data into back[wr_row][wr_col] when wr_en=1, busy=0 and the address is in range; otherwise no write.
REQ-023 SHALL set the commit_pending flag on commit=1 in any state; the flag is cleared only by a swap.
REQ-024 SHALL define FSM states: INIT, IDLE, CLEAR, COPY.
REQ-025 SHALL, in IDLE with a vsync rise and commit_pending=1, toggle front_sel, pulse swap_pulse, clear commit_pending and enter COPY.
REQ-026 SHALL, in COPY, copy the new front bank into the back bank, one cell per cycle, row-major; this takes COLS*ROWS cycles, then IDLE.
REQ-027 SHALL, in IDLE with clr_req=1 and no swap that cycle, enter CLEAR.
REQ-028 SHALL, in CLEAR, write 0 to the back bank, one cell per cycle; this takes COLS*ROWS cycles, then IDLE.
REQ-029 SHALL give a swap priority over clr_req in the same cycle; that clr_req is dropped.
REQ-030 SHALL ignore clr_req outside IDLE.
REQ-031 SHALL hold a commit that arrives while busy until the first vsync rise seen in IDLE.
REQ-032 SHALL assert busy exactly while in INIT, CLEAR or COPY.
REQ-033 SHALL keep the display read port functional in every state; reads never stall.
REQ-034 SHALL wrap the sweep address col 0..COLS-1 then row+1; the last cell is (COLS-1, ROWS-1), after which it exits.

Reset
REQ-035 SHALL, on reset=1, set front_sel=0, frame_count=0, rd_data=0, swap_pulse=0, commit_pending=0, sweep address 0 and state INIT.
REQ-036 SHALL, in INIT, write 0 to both banks, one cell per cycle; this takes COLS*ROWS cycles, busy=1, then IDLE.
REQ-037 SHALL abort any sweep on a reset asserted mid-sweep and restart INIT from cell 0.

Verification
REQ-038 SHALL check: reset then 200 cycles -> busy=1 for exactly 200 cycles; every rd_data=0; frame_count=0.
REQ-039 SHALL check: write (3,5)=3'b101, commit, vsync rise -> swap_pulse for 1 cycle; rd (3,5)=3'b101 one cycle later; busy for 200 cycles.
REQ-040 SHALL check: write (3,5)=3'b010 while busy -> after COPY the back bank holds 3'b101 at (3,5).
REQ-041 SHALL check: clr_req and a swap-causing vsync rise in the same cycle -> COPY runs, no CLEAR; the back bank equals the front bank.
REQ-042 SHALL check: 2048 vsync rises with FCNT_W=11 -> frame_count wraps to 0; no swap without commit.
REQ-043 SHALL check: wr_col=12 with COLS=10, and rd_col=12 -> no write; rd_data=0.
